// File: rtl/response_release_scheduler_pkg.sv
// Response release scheduler: UID geometry, FSM states and UID field helpers.
package rsched_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int ROW_W    = $clog2(NUM_ROWS);
    localparam int COL_W    = $clog2(NUM_COLS);
    localparam int UID_W    = ROW_W + COL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FREE = 2'd2
    } state_e;

    // Row (ordering class) field of a UID.
    function automatic logic [ROW_W-1:0] uid_row(input logic [UID_W-1:0] uid);
        return uid[UID_W-1:COL_W];
    endfunction

    // Column (slot within the row) field of a UID.
    function automatic logic [COL_W-1:0] uid_col(input logic [UID_W-1:0] uid);
        return uid[COL_W-1:0];
    endfunction

endpackage

// File: rtl/response_release_scheduler_if.sv
// Single-beat read response channel towards the master.
interface response_release_scheduler_if #(
    parameter int DATA_WIDTH = 256,
    parameter int RESP_WIDTH = 2,
    parameter int ID_WIDTH   = 4
) ();

    logic                  m_rvalid;
    logic                  m_rready;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic [RESP_WIDTH-1:0] m_rresp;
    logic [ID_WIDTH-1:0]   m_rid;
    logic                  m_rlast;

    modport master (
        output m_rvalid, m_rdata, m_rresp, m_rid, m_rlast,
        input  m_rready
    );

    modport slave (
        input  m_rvalid, m_rdata, m_rresp, m_rid, m_rlast,
        output m_rready
    );

endinterface

// File: rtl/response_release_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   c;
    logic found;

    // Scan upward from the pointer and stop at the first requester.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/response_release_scheduler.sv
// Releases parked read responses in per-row issue order and drives the park
// alloc/free handshakes; one response in flight at a time.
module response_release_scheduler
    import rsched_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int RESP_WIDTH = 2,
    parameter int ID_WIDTH   = 4,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic [UID_W-1:0]      iss_uid,
    input  logic                  park_evt,
    input  logic [UID_W-1:0]      park_evt_uid,
    output logic                  alloc_req,
    output logic [UID_W-1:0]      alloc_uid,
    input  logic                  alloc_gnt,
    input  logic [DATA_WIDTH-1:0] park_data,
    input  logic [RESP_WIDTH-1:0] park_resp,
    input  logic [ID_WIDTH-1:0]   park_orig_id,
    input  logic [TAG_WIDTH-1:0]  park_tagid,
    output logic                  free_req,
    output logic [UID_W-1:0]      free_uid,
    input  logic                  free_ack,
    response_release_scheduler_if.master r_if,
    output logic                  retire_valid,
    output logic [UID_W-1:0]      retire_uid,
    output logic                  err_sticky
);

    localparam logic [COL_W:0] FULL_CNT = (COL_W+1)'(NUM_COLS);

    logic [COL_W-1:0]             fifo_mem [NUM_ROWS][NUM_COLS];
    logic [COL_W-1:0]             rd_ptr   [NUM_ROWS];
    logic [COL_W-1:0]             wr_ptr   [NUM_ROWS];
    logic [COL_W:0]               cnt      [NUM_ROWS];
    logic [COL_W-1:0]             head_col [NUM_ROWS];
    logic [NUM_ROWS*NUM_COLS-1:0] parked;
    state_e                       state;
    logic [ROW_W-1:0]             rr_ptr;
    logic [UID_W-1:0]             cur_uid;

    logic [ROW_W-1:0]    iss_row, evt_row, pop_row, pick_idx;
    logic [COL_W-1:0]    iss_col, evt_col;
    logic [NUM_ROWS-1:0] eligible, pick_gnt, push_hit, pop_hit;
    logic                push, pop, evt_known, evt_dup, evt_err;
    logic                unused_tag;

    // The tag is not carried on the R channel.
    assign unused_tag = ^park_tagid;

    assign iss_row   = uid_row(iss_uid);
    assign iss_col   = uid_col(iss_uid);
    assign evt_row   = uid_row(park_evt_uid);
    assign evt_col   = uid_col(park_evt_uid);
    assign pop_row   = uid_row(cur_uid);
    assign iss_ready = (cnt[iss_row] != FULL_CNT);
    assign push      = iss_valid && iss_ready;
    assign pop       = (state == FREE) && free_ack;

    // Per-row head, eligibility (head parked) and push/pop row decode.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            head_col[r] = fifo_mem[r][rd_ptr[r]];
            eligible[r] = (cnt[r] != '0) && parked[{ROW_W'(r), head_col[r]}];
            push_hit[r] = push && (iss_row == ROW_W'(r));
            pop_hit[r]  = pop && (pop_row == ROW_W'(r));
        end
    end

    // A park event must name an outstanding UID whose bit is clear; a bit
    // being freed this cycle counts as clear since the slot has a new occupant.
    always_comb begin
        evt_known = 1'b0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (((COL_W+1)'(i) < cnt[evt_row]) &&
                (fifo_mem[evt_row][rd_ptr[evt_row] + COL_W'(i)] == evt_col))
                evt_known = 1'b1;
        end
        evt_dup = parked[park_evt_uid] && !(pop && (cur_uid == park_evt_uid));
        evt_err = park_evt && (evt_dup || !evt_known);
    end

    rr_arbiter #(.N(NUM_ROWS), .IW(ROW_W)) u_arb (
        .req (eligible),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign alloc_req    = (state == IDLE) && (|pick_gnt);
    assign alloc_uid    = alloc_req ? {pick_idx, head_col[pick_idx]} : '0;
    assign free_uid     = free_req ? cur_uid : '0;
    assign r_if.m_rlast = 1'b1;

    // Order FIFO storage; entries above the count are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[iss_row][wr_ptr[iss_row]] <= iss_col;
    end

    // Order FIFO pointers and counts; a same-row push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                rd_ptr[r] <= '0;
                wr_ptr[r] <= '0;
                cnt[r]    <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (push_hit[r]) wr_ptr[r] <= wr_ptr[r] + COL_W'(1);
                if (pop_hit[r])  rd_ptr[r] <= rd_ptr[r] + COL_W'(1);
                if (push_hit[r] && !pop_hit[r])      cnt[r] <= cnt[r] + (COL_W+1)'(1);
                else if (pop_hit[r] && !push_hit[r]) cnt[r] <= cnt[r] - (COL_W+1)'(1);
            end
        end
    end

    // Parked bitmap: cleared on free, set on park; set wins on a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parked <= '0;
        end else begin
            if (pop)      parked[cur_uid]      <= 1'b0;
            if (park_evt) parked[park_evt_uid] <= 1'b1;
        end
    end

    // Sticky protocol error: bad park event or a refused allocation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                       err_sticky <= 1'b0;
        else if (evt_err || (alloc_req && !alloc_gnt)) err_sticky <= 1'b1;
    end

    // Release FSM: pick and fetch, present on R, then free the park slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cur_uid       <= '0;
            free_req      <= 1'b0;
            retire_valid  <= 1'b0;
            retire_uid    <= '0;
            r_if.m_rvalid <= 1'b0;
            r_if.m_rdata  <= '0;
            r_if.m_rresp  <= '0;
            r_if.m_rid    <= '0;
        end else begin
            retire_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (alloc_req) begin
                        rr_ptr <= pick_idx + ROW_W'(1);
                        if (alloc_gnt) begin
                            cur_uid       <= alloc_uid;
                            r_if.m_rdata  <= park_data;
                            r_if.m_rresp  <= park_resp;
                            r_if.m_rid    <= park_orig_id;
                            r_if.m_rvalid <= 1'b1;
                            state         <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (r_if.m_rready) begin
                        r_if.m_rvalid <= 1'b0;
                        free_req      <= 1'b1;
                        state         <= FREE;
                    end
                end
                FREE: begin
                    if (free_ack) begin
                        free_req     <= 1'b0;
                        retire_valid <= 1'b1;
                        retire_uid   <= cur_uid;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_response_release_scheduler.sv
// Bench for response_release_scheduler: queue-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_response_release_scheduler;
    import rsched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         iss_valid = 1'b0;
    logic         iss_ready;
    logic [3:0]   iss_uid = '0;
    logic         park_evt = 1'b0;
    logic [3:0]   park_evt_uid = '0;
    logic         alloc_req, alloc_gnt, free_req, free_ack;
    logic [3:0]   alloc_uid, free_uid, retire_uid;
    logic [255:0] park_data;
    logic [1:0]   park_resp;
    logic [3:0]   park_orig_id, park_tagid;
    logic         retire_valid, err_sticky;
    logic         gnt_en = 1'b1, ack_en = 1'b1, rready = 1'b1;

    int tests = 0;
    int fails = 0;

    function automatic logic [255:0] pdata(input logic [3:0] u);
        return {8{28'hDA7A000, u}};
    endfunction

    // Park model: grants and acks on request, returns data keyed by UID.
    assign alloc_gnt    = gnt_en & alloc_req;
    assign free_ack     = ack_en & free_req;
    assign park_data    = pdata(alloc_uid);
    assign park_resp    = alloc_uid[1:0];
    assign park_orig_id = alloc_uid ^ 4'h5;
    assign park_tagid   = ~alloc_uid;

    response_release_scheduler_if r_if ();
    assign r_if.m_rready = rready;

    response_release_scheduler dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_uid(iss_uid),
        .park_evt(park_evt), .park_evt_uid(park_evt_uid),
        .alloc_req(alloc_req), .alloc_uid(alloc_uid), .alloc_gnt(alloc_gnt),
        .park_data(park_data), .park_resp(park_resp),
        .park_orig_id(park_orig_id), .park_tagid(park_tagid),
        .free_req(free_req), .free_uid(free_uid), .free_ack(free_ack),
        .r_if(r_if),
        .retire_valid(retire_valid), .retire_uid(retire_uid),
        .err_sticky(err_sticky)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: outstanding UIDs in global issue order; a row's
    // order is the subsequence of that row.
    logic [3:0]   oq[$];
    bit           pk [16];
    int           ph;          // 0 idle, 1 presenting, 2 freeing
    logic [3:0]   cur, mret_uid, mid;
    int           rr;
    bit           merr, mret;
    logic [255:0] md;
    logic [1:0]   mresp;
    logic [3:0]   rq[$];       // delivered RIDs
    logic [3:0]   retq[$];     // retired UIDs
    int           retcyc[$];

    function automatic int row_cnt(input int r);
        int n = 0;
        foreach (oq[i]) if (int'(oq[i][3:2]) == r) n++;
        return n;
    endfunction

    function automatic int row_head(input int r);
        foreach (oq[i]) if (int'(oq[i][3:2]) == r) return int'(oq[i]);
        return -1;
    endfunction

    function automatic bit in_oq(input logic [3:0] u);
        foreach (oq[i]) if (oq[i] == u) return 1'b1;
        return 1'b0;
    endfunction

    bit         pv, e_ready;
    int         pr, h;
    logic [3:0] pu;

    always @(negedge clk) begin
        if (r_if.m_rvalid && r_if.m_rready) rq.push_back(r_if.m_rid);
        if (retire_valid) begin
            retq.push_back(retire_uid);
            retcyc.push_back(cyc);
        end
        if (!rst) begin
            oq.delete();
            foreach (pk[i]) pk[i] = 1'b0;
            ph = 0; cur = '0; rr = 0; merr = 1'b0; mret = 1'b0;
            mret_uid = '0; md = '0; mresp = '0; mid = '0;
        end
        e_ready = row_cnt(int'(iss_uid[3:2])) < NUM_COLS;
        pv = 1'b0; pr = 0; pu = '0;
        if (ph == 0) begin
            for (int k = 0; k < NUM_ROWS; k++) begin
                h = row_head((rr + k) % NUM_ROWS);
                if (!pv && h >= 0 && pk[h]) begin
                    pv = 1'b1; pr = (rr + k) % NUM_ROWS; pu = 4'(h);
                end
            end
        end
        chk("iss_ready", iss_ready, e_ready);
        chk("alloc_req", alloc_req, pv);
        chk("alloc_uid", alloc_uid, pu);
        chk("m_rvalid", r_if.m_rvalid, ph == 1);
        chk("m_rdata", r_if.m_rdata, md);
        chk("m_rresp", r_if.m_rresp, mresp);
        chk("m_rid", r_if.m_rid, mid);
        chk("m_rlast", r_if.m_rlast, 1'b1);
        chk("free_req", free_req, ph == 2);
        chk("free_uid", free_uid, (ph == 2) ? cur : 4'h0);
        chk("retire_valid", retire_valid, mret);
        chk("retire_uid", retire_uid, mret_uid);
        chk("err_sticky", err_sticky, merr);
        if (rst) begin
            mret = 1'b0;
            if (park_evt && (!in_oq(park_evt_uid) ||
                (pk[park_evt_uid] && !(ph == 2 && free_ack && cur == park_evt_uid))))
                merr = 1'b1;
            if (pv) begin
                rr = (pr + 1) % NUM_ROWS;
                if (alloc_gnt) begin
                    cur = pu; md = pdata(pu); mresp = pu[1:0]; mid = pu ^ 4'h5; ph = 1;
                end else begin
                    merr = 1'b1;
                end
            end else if (ph == 1 && r_if.m_rready) begin
                ph = 2;
            end else if (ph == 2 && free_ack) begin
                for (int i = 0; i < oq.size(); i++)
                    if (oq[i] == cur) begin oq.delete(i); break; end
                pk[cur] = 1'b0; mret = 1'b1; mret_uid = cur; ph = 0;
            end
            if (iss_valid && e_ready) oq.push_back(iss_uid);
            if (park_evt) pk[park_evt_uid] = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] u);
        iss_valid = 1'b1; iss_uid = u;
        step();
        iss_valid = 1'b0;
    endtask

    task automatic park(input logic [3:0] u);
        park_evt = 1'b1; park_evt_uid = u;
        step();
        park_evt = 1'b0;
    endtask

    task automatic do_reset();
        iss_valid = 1'b0; park_evt = 1'b0; gnt_en = 1'b1; ack_en = 1'b1; rready = 1'b1;
        rst = 1'b0;
        step();
        step();
        rq.delete(); retq.delete(); retcyc.delete();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_iss_ready", iss_ready, 1'b1);
        chk("rst_m_rlast", r_if.m_rlast, 1'b1);
        chk("rst_m_rvalid", r_if.m_rvalid, 1'b0);
        chk("rst_alloc_req", alloc_req, 1'b0);
        chk("rst_err", err_sticky, 1'b0);

        // 1: out-of-order park, in-order release within a row
        issue(4'h0); issue(4'h1); park(4'h1);
        chk("t1_no_alloc_early", alloc_req, 1'b0);
        step();
        chk("t1_no_alloc_idle", alloc_req, 1'b0);
        park(4'h0);
        chk("t1_alloc_req", alloc_req, 1'b1);
        chk("t1_alloc_uid", alloc_uid, 4'h0);
        step();
        chk("t1_latency_rvalid", r_if.m_rvalid, 1'b1);
        chk("t1_first_rid", r_if.m_rid, 4'h5);
        for (int i = 0; i < 40 && retq.size() < 2; i++) step();
        chk("t1_retire_count", retq.size(), 2);
        chk("t1_r_count", rq.size(), 2);
        if (rq.size() == 2) begin
            chk("t1_r0", rq[0], 4'h5);
            chk("t1_r1", rq[1], 4'h4);
        end
        if (retq.size() == 2) begin
            chk("t1_ret0", retq[0], 4'h0);
            chk("t1_ret1", retq[1], 4'h1);
        end

        // 2: all four row heads ready together, round robin from row 0
        do_reset();
        rready = 1'b0;
        issue(4'hC); issue(4'hD); issue(4'h0); issue(4'h4); issue(4'h8);
        park(4'hC); park(4'hD); park(4'h0); park(4'h4); park(4'h8);
        rready = 1'b1;
        for (int i = 0; i < 60 && retq.size() < 5; i++) step();
        chk("t2_retire_count", retq.size(), 5);
        if (rq.size() == 5) begin
            chk("t2_r0", rq[0], 4'h9);
            chk("t2_r1", rq[1], 4'h5);
            chk("t2_r2", rq[2], 4'h1);
            chk("t2_r3", rq[3], 4'hD);
            chk("t2_r4", rq[4], 4'h8);
        end else begin
            chk("t2_r_count", rq.size(), 5);
        end
        if (retcyc.size() == 5) chk("t2_four_in_12", retcyc[4] - retcyc[0], 12);

        // 3: backpressure holds the response stable
        do_reset();
        rready = 1'b0;
        issue(4'h5); park(4'h5);
        for (int i = 0; i < 20 && !r_if.m_rvalid; i++) step();
        chk("t3_rvalid_up", r_if.m_rvalid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_rvalid", r_if.m_rvalid, 1'b1);
            chk("t3_hold_rid", r_if.m_rid, 4'h0);
            chk("t3_hold_rdata", r_if.m_rdata, {8{32'hDA7A0005}});
            chk("t3_no_free", free_req, 1'b0);
            step();
        end
        rready = 1'b1;
        step();
        chk("t3_free_req", free_req, 1'b1);
        chk("t3_free_uid", free_uid, 4'h5);
        chk("t3_rvalid_down", r_if.m_rvalid, 1'b0);

        // 4: full row, readiness returns only after the pop
        do_reset();
        issue(4'h8); issue(4'h9); issue(4'hA); issue(4'hB);
        chk("t4_full", iss_ready, 1'b0);
        park(4'h8);
        for (int i = 0; i < 20 && !free_req; i++) step();
        chk("t4_free_seen", free_req, 1'b1);
        iss_valid = 1'b1; iss_uid = 4'h8;
        #1;
        chk("t4_full_during_pop", iss_ready, 1'b0);
        step();
        chk("t4_ready_after_pop", iss_ready, 1'b1);
        chk("t4_retire", retire_valid, 1'b1);
        chk("t4_retire_uid", retire_uid, 4'h8);
        step();
        iss_valid = 1'b0;
        #1;
        chk("t4_refilled", iss_ready, 1'b0);

        // 5: refused grant, duplicate park, unknown park
        do_reset();
        gnt_en = 1'b0;
        issue(4'h3); park(4'h3);
        chk("t5_alloc_req", alloc_req, 1'b1);
        step();
        chk("t5_err_nogrant", err_sticky, 1'b1);
        chk("t5_no_rvalid", r_if.m_rvalid, 1'b0);
        chk("t5_still_idle", alloc_req, 1'b1);
        do_reset();
        chk("t5_err_cleared", err_sticky, 1'b0);
        issue(4'h6); park(4'h6); park(4'h6);
        chk("t5_err_dup", err_sticky, 1'b1);
        do_reset();
        park(4'hF);
        chk("t5_err_unknown", err_sticky, 1'b1);
        chk("t5_unknown_no_alloc", alloc_req, 1'b0);

        // 6: reset while presenting
        do_reset();
        issue(4'h2); park(4'h2);
        rready = 1'b0;
        for (int i = 0; i < 20 && !r_if.m_rvalid; i++) step();
        chk("t6_rvalid_up", r_if.m_rvalid, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rvalid_async", r_if.m_rvalid, 1'b0);
        step(); step();
        retq.delete(); rready = 1'b1;
        rst = 1'b1;
        step();
        chk("t6_iss_ready", iss_ready, 1'b1);
        chk("t6_no_alloc", alloc_req, 1'b0);
        step(); step(); step();
        chk("t6_no_retire", retq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
